// File: rtl/variable_length_unpacker_if.sv
// Handshake and status bundle between the stream reader/decoder side and the unpacker.
interface variable_length_unpacker_if #(
   parameter int unsigned WIDTH_IN     = 8,
   parameter int unsigned WIDTH_OUT    = 8,
   parameter int unsigned BUFFER_WIDTH = 16,
   parameter int unsigned COUNT_WIDTH  = 32
);
   localparam int unsigned PopW  = $clog2(WIDTH_OUT) + 1;
   localparam int unsigned SizeW = $clog2(BUFFER_WIDTH) + 1;

   logic                   flush;
   logic                   push;
   logic [WIDTH_IN-1:0]    d;
   logic                   ready;
   logic [PopW-1:0]        pop;
   logic [WIDTH_OUT-1:0]   q;
   logic [PopW-1:0]        q_avail;
   logic [SizeW-1:0]       size;
   logic                   overflow;
   logic                   underflow;
   logic [COUNT_WIDTH-1:0] consumed;

   modport master (
      output flush, push, d, pop,
      input  ready, q, q_avail, size, overflow, underflow, consumed
   );

   modport slave (
      input  flush, push, d, pop,
      output ready, q, q_avail, size, overflow, underflow, consumed
   );
endinterface

// File: rtl/variable_length_unpacker.sv
// Variable-length bit unpacker: fixed-width words in, 0..WIDTH_OUT bits consumed per cycle.
// Pop is applied before push each cycle; flush overrides both.
module variable_length_unpacker #(
   parameter int unsigned WIDTH_IN     = 8,
   parameter int unsigned WIDTH_OUT    = 8,
   parameter int unsigned BUFFER_WIDTH = 16,
   parameter int unsigned MSB_FIRST    = 0,
   parameter int unsigned COUNT_WIDTH  = 32
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   variable_length_unpacker_if.slave bus
);
   localparam int unsigned PopW  = $clog2(WIDTH_OUT) + 1;
   localparam int unsigned SizeW = $clog2(BUFFER_WIDTH) + 1;

   logic [BUFFER_WIDTH-1:0] buf_q, buf_d;
   logic [SizeW-1:0]        size_q, size_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                    ready_c;
   logic [SizeW-1:0]        pop_ext;

   assign ready_c = (size_q <= SizeW'(BUFFER_WIDTH - WIDTH_IN));
   assign pop_ext = SizeW'(bus.pop);

   // Next state: pop at the head, then append at the post-pop tail.
   always_comb begin
      buf_d  = buf_q;
      size_d = size_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      cnt_d  = cnt_q;
      if (bus.flush) begin
         buf_d  = '0;
         size_d = '0;
         ovf_d  = 1'b0;
         unf_d  = 1'b0;
         cnt_d  = '0;
      end else begin
         if (pop_ext <= size_q) begin
            if (MSB_FIRST != 0) buf_d = buf_q << pop_ext;
            else                buf_d = buf_q >> pop_ext;
            size_d = size_q - pop_ext;
            cnt_d  = cnt_q + COUNT_WIDTH'(bus.pop);
         end else begin
            unf_d = 1'b1;
         end
         if (bus.push && ready_c) begin
            if (MSB_FIRST != 0)
               buf_d = buf_d | ((BUFFER_WIDTH'(bus.d) << (BUFFER_WIDTH - WIDTH_IN)) >> size_d);
            else
               buf_d = buf_d | (BUFFER_WIDTH'(bus.d) << size_d);
            size_d = size_d + SizeW'(WIDTH_IN);
         end else if (bus.push) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q  <= '0;
         size_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         buf_q  <= buf_d;
         size_q <= size_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         cnt_q  <= cnt_d;
      end
   end

   // Peek decodes straight from the buffer; bits past size are already zero.
   assign bus.q         = (MSB_FIRST != 0) ? buf_q[BUFFER_WIDTH-1 -: WIDTH_OUT]
                                           : buf_q[WIDTH_OUT-1:0];
   assign bus.q_avail   = (size_q >= SizeW'(WIDTH_OUT)) ? PopW'(WIDTH_OUT) : PopW'(size_q);
   assign bus.ready     = ready_c;
   assign bus.size      = size_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.consumed  = cnt_q;
endmodule

// File: tb/tb_variable_length_unpacker.sv
// Bench: LSB-first and MSB-first unpackers driven in lockstep against a bit-queue stream model.
module tb_variable_length_unpacker;
   localparam int unsigned WIN = 8, WOUT = 8, BW = 16, CW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;

   bit   st_l[$];
   bit   st_m[$];
   logic m_ovf, m_unf;
   logic [CW-1:0] m_cons;

   variable_length_unpacker_if #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .COUNT_WIDTH(CW)) ifl ();
   variable_length_unpacker_if #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .COUNT_WIDTH(CW)) ifm ();

   variable_length_unpacker #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .MSB_FIRST(0), .COUNT_WIDTH(CW))
      u_lsb (.clk_i(clk), .rst_ni(rst_n), .bus(ifl));
   variable_length_unpacker #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .BUFFER_WIDTH(BW), .MSB_FIRST(1), .COUNT_WIDTH(CW))
      u_msb (.clk_i(clk), .rst_ni(rst_n), .bus(ifm));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WOUT-1:0] model_q(input bit msb);
      logic [WOUT-1:0] r = '0;
      int n = msb ? st_m.size() : st_l.size();
      for (int i = 0; i < WOUT && i < n; i++) begin
         if (msb) r[WOUT-1-i] = st_m[i];
         else     r[i]        = st_l[i];
      end
      return r;
   endfunction

   task automatic model_reset();
      st_l.delete();
      st_m.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_cons = '0;
   endtask

   task automatic model_step(input logic p, input logic [WIN-1:0] dd, input int pp, input logic f);
      bit rdy;
      if (f) begin
         model_reset();
      end else begin
         rdy = (st_l.size() <= BW - WIN);
         if (pp <= st_l.size()) begin
            for (int i = 0; i < pp; i++) begin
               void'(st_l.pop_front());
               void'(st_m.pop_front());
            end
            m_cons = m_cons + CW'(pp);
         end else begin
            m_unf = 1'b1;
         end
         if (p && rdy) begin
            for (int i = 0; i < WIN; i++) begin
               st_l.push_back(dd[i]);
               st_m.push_back(dd[WIN-1-i]);
            end
         end else if (p) begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      int n = st_l.size();
      int av = (n < WOUT) ? n : WOUT;
      chk("size_l",  64'(ifl.size),      64'(n));
      chk("size_m",  64'(ifm.size),      64'(n));
      chk("q_l",     64'(ifl.q),         64'(model_q(1'b0)));
      chk("q_m",     64'(ifm.q),         64'(model_q(1'b1)));
      chk("avail_l", 64'(ifl.q_avail),   64'(av));
      chk("avail_m", 64'(ifm.q_avail),   64'(av));
      chk("ready_l", 64'(ifl.ready),     64'(n <= BW - WIN));
      chk("ready_m", 64'(ifm.ready),     64'(n <= BW - WIN));
      chk("ovf_l",   64'(ifl.overflow),  64'(m_ovf));
      chk("ovf_m",   64'(ifm.overflow),  64'(m_ovf));
      chk("unf_l",   64'(ifl.underflow), 64'(m_unf));
      chk("unf_m",   64'(ifm.underflow), 64'(m_unf));
      chk("cons_l",  64'(ifl.consumed),  64'(m_cons));
      chk("cons_m",  64'(ifm.consumed),  64'(m_cons));
   endtask

   task automatic cycle(input logic p, input logic [WIN-1:0] dd, input int pp, input logic f);
      ifl.push = p;  ifl.d = dd;  ifl.pop = 4'(pp);  ifl.flush = f;
      ifm.push = p;  ifm.d = dd;  ifm.pop = 4'(pp);  ifm.flush = f;
      @(posedge clk);
      model_step(p, dd, pp, f);
      #1;
      check_all();
   endtask

   initial begin
      ifl.push = 1'b0; ifl.d = '0; ifl.pop = '0; ifl.flush = 1'b0;
      ifm.push = 1'b0; ifm.d = '0; ifm.pop = '0; ifm.flush = 1'b0;
      model_reset();
      #1;
      check_all();
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      check_all();

      // Push then partial pop, both bit orders
      cycle(1'b1, 8'hA5, 0, 1'b0);
      chk("t1_q_a5",   64'(ifl.q), 64'hA5);
      chk("t5_q_a5",   64'(ifm.q), 64'hA5);
      chk("t1_size8",  64'(ifl.size), 64'd8);
      cycle(1'b0, 8'h00, 3, 1'b0);
      chk("t1_q_14",   64'(ifl.q), 64'h14);
      chk("t5_q_28",   64'(ifm.q), 64'h28);
      chk("t1_avail5", 64'(ifl.q_avail), 64'd5);
      chk("t1_cons3",  64'(ifl.consumed), 64'd3);

      // Simultaneous pop and push
      cycle(1'b0, 8'h00, 0, 1'b1);
      cycle(1'b1, 8'hA5, 0, 1'b0);
      cycle(1'b1, 8'hFF, 3, 1'b0);
      chk("t2_size13", 64'(ifl.size), 64'd13);
      chk("t2_q_f4",   64'(ifl.q), 64'hF4);

      // Fill, overflow, drain a full peek
      cycle(1'b0, 8'h00, 0, 1'b1);
      cycle(1'b1, 8'h3C, 0, 1'b0);
      cycle(1'b1, 8'hC3, 0, 1'b0);
      chk("t3_ready0", 64'(ifl.ready), 64'd0);
      cycle(1'b1, 8'h11, 0, 1'b0);
      chk("t3_ovf",    64'(ifl.overflow), 64'd1);
      chk("t3_q_keep", 64'(ifl.q), 64'h3C);
      cycle(1'b0, 8'h00, 8, 1'b0);
      chk("t3_size8",  64'(ifl.size), 64'd8);
      chk("t3_ready1", 64'(ifl.ready), 64'd1);

      // Underflow keeps state; exact drain to empty
      cycle(1'b0, 8'h00, 0, 1'b1);
      cycle(1'b1, 8'hA5, 0, 1'b0);
      cycle(1'b0, 8'h00, 3, 1'b0);
      cycle(1'b0, 8'h00, 6, 1'b0);
      chk("t4_unf",    64'(ifl.underflow), 64'd1);
      chk("t4_size5",  64'(ifl.size), 64'd5);
      chk("t4_cons3",  64'(ifl.consumed), 64'd3);
      cycle(1'b0, 8'h00, 5, 1'b0);
      chk("t4_size0",  64'(ifl.size), 64'd0);
      chk("t4_q0",     64'(ifl.q), 64'd0);
      chk("t4_unf_st", 64'(ifl.underflow), 64'd1);

      // Flush with both flags set overrides push/pop
      cycle(1'b0, 8'h00, 0, 1'b1);
      cycle(1'b0, 8'h00, 1, 1'b0);
      cycle(1'b1, 8'h5A, 0, 1'b0);
      cycle(1'b1, 8'h96, 0, 1'b0);
      cycle(1'b1, 8'h77, 0, 1'b0);
      cycle(1'b0, 8'h00, 3, 1'b0);
      chk("t6_size13", 64'(ifl.size), 64'd13);
      chk("t6_flags",  64'({ifl.overflow, ifl.underflow}), 64'd3);
      cycle(1'b1, 8'hEE, 2, 1'b1);
      chk("t6_size0",  64'(ifl.size), 64'd0);
      chk("t6_cons0",  64'(ifl.consumed), 64'd0);
      chk("t6_flags0", 64'({ifl.overflow, ifl.underflow}), 64'd0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 9) < 6), 8'($urandom), int'($urandom_range(0, 8)),
               ($urandom_range(0, 49) == 0));
      end

      // Asynchronous reset mid-stream, away from any clock edge
      cycle(1'b1, 8'hC9, 0, 1'b0);
      cycle(1'b1, 8'h3B, 1, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_size0", 64'(ifl.size), 64'd0);
      chk("rst_ready", 64'(ifm.ready), 64'd1);
      #3 rst_n = 1'b1;
      cycle(1'b1, 8'h81, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/variable_length_unpacker.md
Name: variable_length_unpacker

Overview:
- Parametrised successor to the single-channel variable-length bit buffer.
- Accepts fixed-width input words and lets the downstream decoder consume a variable number of bits per cycle, from 0 to WIDTH_OUT inclusive.
- Adds the following over the previous generation:
  - valid/ready on both sides;
  - selectable bit order;
  - a masked peek with an available-bit count;
  - flush;
  - sticky overflow/underflow flags;
  - a consumed-bit counter.
- Sits between the packed-stream reader and the entropy/Huffman decoders.

Parameters:
- WIDTH_IN, 8: input word width, in bits.
- WIDTH_OUT, 8: peek width; maximum bits consumed per cycle.
- BUFFER_WIDTH, 16: storage, in bits. Must be at least WIDTH_IN + WIDTH_OUT.
- MSB_FIRST, 0: bit order. 0 = the stream begins at bit 0 of d. 1 = the stream begins at the MSB of d.
- COUNT_WIDTH, 32: width of the consumed-bit counter.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous clear of buffer, size, flags and counter.
- push, input, 1: input word valid.
- d, input, WIDTH_IN: input word.
- ready, output, 1: can accept a push this cycle.
- pop, input, clog2(WIDTH_OUT)+1: number of bits to consume this cycle.
- q, output, WIDTH_OUT: next stream bits. Bits beyond q_avail are zero.
- q_avail, output, clog2(WIDTH_OUT)+1: min(size, WIDTH_OUT).
- size, output, clog2(BUFFER_WIDTH)+1: bits currently held.
- overflow, output, 1: sticky. Set when a push is made while ready=0.
- underflow, output, 1: sticky. Set when pop > size.
- consumed, output, COUNT_WIDTH: total bits popped since reset or flush. Wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (rst low, asynchronous):
  - buffer and size return to 0, giving q=0, q_avail=0, ready=1.
  - overflow=0, underflow=0, consumed=0.
  - Deassertion is synchronised externally.
  - Reset mid-stream discards all held bits.
- ready = (size <= BUFFER_WIDTH - WIDTH_IN). It is combinational from registered size and has no dependency on the same-cycle pop.
- Registered outputs: size, overflow, underflow, consumed. q and q_avail decode combinationally from registers.
- Per-cycle order of operations when flush=0:
  1. Pop is applied first. If pop <= size: remove pop bits from the stream head, size -= pop, consumed += pop.
  2. If pop > size: the pop is ignored entirely (buffer, size and consumed are unchanged) and underflow <= 1.
  3. Push is then applied at the post-pop tail. If push and ready: append d, size += WIDTH_IN. Because ready is evaluated before the pop, a push that is accepted always fits.
  4. If push and !ready: d is dropped and overflow <= 1.
- Bit order:
  - MSB_FIRST=0: the head is buffer bit 0. Pop shifts right. d is ORed in at bit position size. q = buffer[WIDTH_OUT-1:0].
  - MSB_FIRST=1: the head is buffer bit BUFFER_WIDTH-1. Pop shifts left. d is placed with its MSB at position BUFFER_WIDTH-1-size. q = top WIDTH_OUT bits.
- Invariant: buffer bits outside the valid size region are always zero. Shifts fill with zero and flush zeroes the buffer.
- Flush (synchronous, has priority over push and pop in the same cycle): state returns to its reset values. The push and pop that cycle are discarded and no flag is set.
- Latency: pushed data is visible on q the next cycle. A pop of 0 is a no-op.
- Flags clear only on reset or flush.

Test Plan (WIDTH_IN=8, WIDTH_OUT=8, BUFFER_WIDTH=16, MSB_FIRST=0 unless noted):
1. Reset, then push d=0xA5 -> next cycle size=8, q=0xA5, q_avail=8, ready=1. Then pop=3 -> size=5, q=0x14, q_avail=5, consumed=3.
2. From size=8, q=0xA5: pop=3 and push d=0xFF in the same cycle -> size=13, q=0xF4, consumed=3.
3. Fill to size=16 -> ready=0. Push 0x11 -> overflow=1, size=16, q unchanged. Pop=8 (WIDTH_OUT) -> size=8, ready=1.
4. At size=5, pop=6 -> underflow=1, size=5, consumed unchanged. Then pop=5 -> size=0, q=0, underflow stays 1.
5. MSB_FIRST=1: push 0xA5 -> q=0xA5. Then pop=3 -> q=0x28, q_avail=5.
6. At size=13 with both flags set: flush with push=1, pop=2 -> next cycle size=0, q=0, overflow=0, underflow=0, consumed=0. Then assert rst low asynchronously mid-stream -> outputs reach their reset values without a clock edge.
